// File: rtl/fir_pkg.sv
// Shared constants and state encoding for the decimating FIR sequencer and its helpers.
package fir_pkg;

  localparam int TAPS      = 256;
  localparam int DRAIN_CYC = 5;
  localparam int MAC_W     = 56;
  localparam int DATA_W    = 24;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

endpackage

// File: rtl/fir_out_sat.sv
// Arithmetic right shift of a MAC accumulator followed by saturation to a signed sample.
module fir_out_sat
  import fir_pkg::*;
#(
  parameter int SHIFT = 23
) (
  input  logic signed [MAC_W-1:0]  acc,
  output logic        [DATA_W-1:0] sat
);

  logic signed [MAC_W-1:0]      shifted;
  logic        [MAC_W-DATA_W:0] upper;

  assign shifted = acc >>> SHIFT;
  assign upper   = shifted[MAC_W-1:DATA_W-1];

  // The value fits only when every bit from the output sign bit upward agrees.
  always_comb begin
    sat = shifted[DATA_W-1:0];
    if (!((&upper) || !(|upper))) begin
      sat = shifted[MAC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fir_sequencer.sv
// Sequencer for a decimating FIR: writes samples into a circular RAM and, once per
// decimation period, streams TAPS sample/coefficient pairs through an external MAC.
module fir_sequencer
  import fir_pkg::*;
#(
  parameter int TAPS      = fir_pkg::TAPS,
  parameter int TAP_AW    = $clog2(TAPS),
  parameter int BUF_AW    = 9,
  parameter int DECIM     = 8,
  parameter int OUT_SHIFT = 23,
  parameter int DRAIN_CYC = fir_pkg::DRAIN_CYC
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_strobe,
  input  logic [DATA_W-1:0] in_data,
  output logic              buf_we,
  output logic [BUF_AW-1:0] buf_waddr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic [BUF_AW-1:0] buf_raddr,
  input  logic [DATA_W-1:0] buf_rdata,
  output logic [TAP_AW-1:0] coef_addr,
  input  logic [DATA_W-1:0] coef_rdata,
  output logic              mac_clear,
  output logic [DATA_W-1:0] mac_data_1,
  output logic [DATA_W-1:0] mac_data_2,
  input  logic [MAC_W-1:0]  mac_acc,
  output logic [DATA_W-1:0] out_data,
  output logic              out_strobe,
  output logic              busy,
  output logic              overrun
);

  logic [1:0]        state;
  logic [BUF_AW-1:0] wptr;
  logic [BUF_AW-1:0] snap;
  logic [7:0]        dcnt;
  logic [TAP_AW-1:0] cnt;
  logic              rd_valid_d1;
  logic              trigger;
  logic [DATA_W-1:0] sat_data;

  assign trigger   = in_strobe && (dcnt == 8'(DECIM - 1));
  assign buf_we    = in_strobe;
  assign buf_waddr = wptr;
  assign buf_wdata = in_data;
  assign busy      = (state != IDLE);
  assign mac_clear = (state == IDLE) || (state == CLEAR);
  assign buf_raddr = (state == RUN) ? (snap - BUF_AW'(1) - BUF_AW'(cnt)) : '0;
  assign coef_addr = (state == RUN) ? cnt : '0;

  // RAM and ROM outputs lag the address by a cycle; anything outside that window is stale.
  assign mac_data_1 = rd_valid_d1 ? buf_rdata  : '0;
  assign mac_data_2 = rd_valid_d1 ? coef_rdata : '0;

  fir_out_sat #(.SHIFT(OUT_SHIFT)) u_out_sat (
    .acc (mac_acc),
    .sat (sat_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      dcnt <= '0;
    end else if (in_strobe) begin
      wptr <= wptr + BUF_AW'(1);
      dcnt <= trigger ? 8'd0 : dcnt + 8'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      snap        <= '0;
      cnt         <= '0;
      rd_valid_d1 <= 1'b0;
      out_data    <= '0;
      out_strobe  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      out_strobe  <= 1'b0;
      rd_valid_d1 <= (state == RUN);
      if (trigger && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          // Snapshot the pointer past the triggering write so that sample is tap 0.
          if (trigger) begin
            state <= CLEAR;
            snap  <= wptr + BUF_AW'(1);
          end
        end
        CLEAR: begin
          state <= RUN;
          cnt   <= '0;
        end
        RUN: begin
          if (cnt == TAP_AW'(TAPS - 1)) begin
            state <= DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + TAP_AW'(1);
          end
        end
        DRAIN: begin
          if (cnt == TAP_AW'(DRAIN_CYC - 1)) begin
            state      <= IDLE;
            out_data   <= sat_data;
            out_strobe <= 1'b1;
          end else begin
            cnt <= cnt + TAP_AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
